// File: rtl/noc_leaf_interface_if.sv
// Handshake bundle between a leaf network interface, its PE and its leaf router port.
// The slave view belongs to the leaf interface. The master view belongs to the PE/router side.
interface noc_leaf_interface_if #(
  parameter int unsigned WIDTH_pack = 20,
  parameter int unsigned WIDTH_add  = 5,
  parameter int unsigned WIDTH_type = 2,
  parameter int unsigned WIDTH_data = 8
);
  logic                  pe_tx_valid;
  logic                  pe_tx_ready;
  logic [WIDTH_add-1:0]  pe_tx_dest;
  logic [WIDTH_type-1:0] pe_tx_type;
  logic [WIDTH_data-1:0] pe_tx_data;

  logic                  net_out_valid;
  logic                  net_out_ready;
  logic [WIDTH_pack-1:0] net_out_pack;

  logic                  net_in_valid;
  logic                  net_in_ready;
  logic [WIDTH_pack-1:0] net_in_pack;

  logic                  pe_rx_valid;
  logic                  pe_rx_ready;
  logic [WIDTH_add-1:0]  pe_rx_src;
  logic [WIDTH_type-1:0] pe_rx_type;
  logic [WIDTH_data-1:0] pe_rx_data;

  logic                  misroute_err;
  logic [7:0]            drop_cnt;

  modport slave (
    input  pe_tx_valid, pe_tx_dest, pe_tx_type, pe_tx_data,
    output pe_tx_ready,
    output net_out_valid, net_out_pack,
    input  net_out_ready,
    input  net_in_valid, net_in_pack,
    output net_in_ready,
    output pe_rx_valid, pe_rx_src, pe_rx_type, pe_rx_data,
    input  pe_rx_ready,
    output misroute_err, drop_cnt
  );

  modport master (
    output pe_tx_valid, pe_tx_dest, pe_tx_type, pe_tx_data,
    input  pe_tx_ready,
    input  net_out_valid, net_out_pack,
    output net_out_ready,
    output net_in_valid, net_in_pack,
    input  net_in_ready,
    input  pe_rx_valid, pe_rx_src, pe_rx_type, pe_rx_data,
    output pe_rx_ready,
    input  misroute_err, drop_cnt
  );
endinterface

// File: rtl/noc_leaf_interface.sv
// Leaf NoC interface: packs PE requests into a TX FIFO, filters router packets into an RX FIFO,
// and loops self-addressed requests straight into the RX FIFO.
module noc_leaf_interface #(
  parameter int unsigned          WIDTH_pack = 20,
  parameter int unsigned          WIDTH_add  = 5,
  parameter int unsigned          WIDTH_type = 2,
  parameter int unsigned          WIDTH_data = 8,
  parameter logic [WIDTH_add-1:0] NODE_ADDR  = 5'd1,
  parameter int unsigned          TX_DEPTH   = 4,
  parameter int unsigned          RX_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  noc_leaf_interface_if.slave  bus
);
  localparam int unsigned TYPE_LSB = WIDTH_data;
  localparam int unsigned RCV_LSB  = WIDTH_data + WIDTH_type;
  localparam int unsigned SND_LSB  = RCV_LSB + WIDTH_add;
  localparam int unsigned TX_PW    = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RX_PW    = $clog2(RX_DEPTH) + 1;
  localparam int unsigned CNT_W    = 8;

  logic [WIDTH_pack-1:0] tx_mem [TX_DEPTH];
  logic [WIDTH_pack-1:0] rx_mem [RX_DEPTH];
  logic [TX_PW-1:0]      tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [RX_PW-1:0]      rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic                  misroute_err_q, misroute_err_d;
  logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;

  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic                  is_loop, net_hit, net_in_fire;
  logic                  pe_tx_ready_c, net_in_ready_c;
  logic                  tx_push, tx_pop, rx_push, rx_pop, loop_push, misroute;
  logic [WIDTH_pack-1:0] tx_pkt, rx_push_pkt, tx_head, rx_head;

  // Wrap-bit pointers: full when only the extra MSB differs.
  assign tx_full  = (tx_wr_q ^ tx_rd_q) == TX_PW'(TX_DEPTH);
  assign tx_empty = tx_wr_q == tx_rd_q;
  assign rx_full  = (rx_wr_q ^ rx_rd_q) == RX_PW'(RX_DEPTH);
  assign rx_empty = rx_wr_q == rx_rd_q;

  assign tx_pkt      = {NODE_ADDR, bus.pe_tx_dest, bus.pe_tx_type, bus.pe_tx_data};
  assign is_loop     = bus.pe_tx_dest == NODE_ADDR;
  assign net_hit     = bus.net_in_pack[RCV_LSB +: WIDTH_add] == NODE_ADDR;

  // Network input wins the single RX write port over loopback.
  assign net_in_ready_c = !reset && !rx_full;
  assign net_in_fire    = bus.net_in_valid && net_in_ready_c;
  assign pe_tx_ready_c  = !reset && (is_loop ? (!rx_full && !net_in_fire) : !tx_full);

  assign tx_push     = bus.pe_tx_valid && pe_tx_ready_c && !is_loop;
  assign loop_push   = bus.pe_tx_valid && pe_tx_ready_c && is_loop;
  assign misroute    = net_in_fire && !net_hit;
  assign rx_push     = (net_in_fire && net_hit) || loop_push;
  assign rx_push_pkt = net_in_fire ? bus.net_in_pack : tx_pkt;
  assign tx_pop      = !tx_empty && bus.net_out_ready;
  assign rx_pop      = !rx_empty && bus.pe_rx_ready;

  always_comb begin
    tx_wr_d        = tx_wr_q + TX_PW'(tx_push);
    tx_rd_d        = tx_rd_q + TX_PW'(tx_pop);
    rx_wr_d        = rx_wr_q + RX_PW'(rx_push);
    rx_rd_d        = rx_rd_q + RX_PW'(rx_pop);
    misroute_err_d = misroute_err_q;
    drop_cnt_d     = drop_cnt_q;
    if (misroute) begin
      misroute_err_d = 1'b1;
      if (drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_q        <= '0;
      tx_rd_q        <= '0;
      rx_wr_q        <= '0;
      rx_rd_q        <= '0;
      misroute_err_q <= 1'b0;
      drop_cnt_q     <= '0;
    end else begin
      tx_wr_q        <= tx_wr_d;
      tx_rd_q        <= tx_rd_d;
      rx_wr_q        <= rx_wr_d;
      rx_rd_q        <= rx_rd_d;
      misroute_err_q <= misroute_err_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  // Storage needs no reset; emptiness masks stale entries.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[TX_PW-2:0]] <= tx_pkt;
    if (rx_push) rx_mem[rx_wr_q[RX_PW-2:0]] <= rx_push_pkt;
  end

  assign tx_head = tx_empty ? '0 : tx_mem[tx_rd_q[TX_PW-2:0]];
  assign rx_head = rx_empty ? '0 : rx_mem[rx_rd_q[RX_PW-2:0]];

  assign bus.pe_tx_ready   = pe_tx_ready_c;
  assign bus.net_in_ready  = net_in_ready_c;
  assign bus.net_out_valid = !tx_empty;
  assign bus.net_out_pack  = tx_head;
  assign bus.pe_rx_valid   = !rx_empty;
  assign bus.pe_rx_src     = rx_head[SND_LSB +: WIDTH_add];
  assign bus.pe_rx_type    = rx_head[TYPE_LSB +: WIDTH_type];
  assign bus.pe_rx_data    = rx_head[WIDTH_data-1:0];
  assign bus.misroute_err  = misroute_err_q;
  assign bus.drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_noc_leaf_interface.sv
// Self-checking bench for noc_leaf_interface: directed scenarios plus a random phase,
// compared every cycle against a queue-based model of the leaf interface.
module tb_noc_leaf_interface;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [19:0] tx_q[$];
  logic [19:0] rx_q[$];
  logic        m_err;
  int          m_drop;

  noc_leaf_interface_if bus ();

  noc_leaf_interface #(.NODE_ADDR(5'd1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with inputs already applied; advances to the next negedge.
  task automatic step();
    bit          nin_rdy, tx_rdy, lp, nin_fire, tx_fire, tx_pop, rx_pop;
    logic [19:0] tx_head, rx_head;
    #1;
    if (reset) begin
      tx_q.delete();
      rx_q.delete();
      m_err   = 1'b0;
      m_drop  = 0;
      nin_rdy = 1'b0;
      tx_rdy  = 1'b0;
    end else begin
      nin_rdy = rx_q.size() < 4;
      lp      = bus.pe_tx_dest == 5'd1;
      tx_rdy  = lp ? (rx_q.size() < 4 && !(bus.net_in_valid && nin_rdy)) : (tx_q.size() < 4);
    end
    tx_head = (tx_q.size() != 0) ? tx_q[0] : 20'h0;
    rx_head = (rx_q.size() != 0) ? rx_q[0] : 20'h0;
    check("pe_tx_ready",   20'(bus.pe_tx_ready),   20'(tx_rdy));
    check("net_in_ready",  20'(bus.net_in_ready),  20'(nin_rdy));
    check("net_out_valid", 20'(bus.net_out_valid), 20'(tx_q.size() != 0));
    check("net_out_pack",  bus.net_out_pack,       tx_head);
    check("pe_rx_valid",   20'(bus.pe_rx_valid),   20'(rx_q.size() != 0));
    check("pe_rx_src",     20'(bus.pe_rx_src),     20'(rx_head[19:15]));
    check("pe_rx_type",    20'(bus.pe_rx_type),    20'(rx_head[9:8]));
    check("pe_rx_data",    20'(bus.pe_rx_data),    20'(rx_head[7:0]));
    check("misroute_err",  20'(bus.misroute_err),  20'(m_err));
    check("drop_cnt",      20'(bus.drop_cnt),      20'(m_drop));
    nin_fire = !reset && bus.net_in_valid && nin_rdy;
    tx_fire  = !reset && bus.pe_tx_valid && tx_rdy;
    tx_pop   = !reset && bus.net_out_ready && tx_q.size() != 0;
    rx_pop   = !reset && bus.pe_rx_ready && rx_q.size() != 0;
    @(posedge clk);
    if (tx_pop) void'(tx_q.pop_front());
    if (rx_pop) void'(rx_q.pop_front());
    if (nin_fire) begin
      if (bus.net_in_pack[14:10] == 5'd1) rx_q.push_back(bus.net_in_pack);
      else begin
        m_err  = 1'b1;
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end
    end
    if (tx_fire) begin
      if (bus.pe_tx_dest == 5'd1) rx_q.push_back({5'd1, 5'd1, bus.pe_tx_type, bus.pe_tx_data});
      else tx_q.push_back({5'd1, bus.pe_tx_dest, bus.pe_tx_type, bus.pe_tx_data});
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.pe_tx_valid   = 1'b0;
    bus.pe_tx_dest    = 5'd0;
    bus.pe_tx_type    = 2'd0;
    bus.pe_tx_data    = 8'd0;
    bus.net_in_valid  = 1'b0;
    bus.net_in_pack   = 20'd0;
    bus.net_out_ready = 1'b0;
    bus.pe_rx_ready   = 1'b0;
  endtask

  task automatic pe_send(input logic [4:0] dest, input logic [1:0] typ, input logic [7:0] data);
    bus.pe_tx_valid = 1'b1;
    bus.pe_tx_dest  = dest;
    bus.pe_tx_type  = typ;
    bus.pe_tx_data  = data;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_err    = 1'b0;
    m_drop   = 0;
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    step();

    // Single TX packet with known encoding
    pe_send(5'd5, 2'd2, 8'hA3);
    step();
    bus.pe_tx_valid = 1'b0;
    #1;
    check("tx_pack_const", bus.net_out_pack, 20'h096A3);
    check("tx_valid_const", 20'(bus.net_out_valid), 20'd1);
    step();
    bus.net_out_ready = 1'b1;
    step();
    step();

    // TX FIFO fills to 4 under backpressure, then drains back-to-back
    bus.net_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pe_send(5'($urandom_range(2, 31)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      step();
    end
    #1;
    check("tx_full_block", 20'(bus.pe_tx_ready), 20'd0);
    bus.pe_tx_valid   = 1'b0;
    bus.net_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Router delivers a packet addressed to this leaf
    bus.net_in_valid = 1'b1;
    bus.net_in_pack  = {5'd9, 5'd1, 2'd1, 8'h3C};
    step();
    bus.net_in_valid = 1'b0;
    #1;
    check("rx_src_const", 20'(bus.pe_rx_src), 20'd9);
    check("rx_data_const", 20'(bus.pe_rx_data), 20'h3C);
    bus.pe_rx_ready = 1'b1;
    step();
    step();

    // Misrouted packets: three, then enough to saturate the counter
    bus.net_in_valid = 1'b1;
    bus.net_in_pack  = {5'd3, 5'd7, 2'd0, 8'h11};
    for (int i = 0; i < 3; i++) step();
    bus.net_in_valid = 1'b0;
    #1;
    check("drop_cnt_3", 20'(bus.drop_cnt), 20'd3);
    check("misroute_set", 20'(bus.misroute_err), 20'd1);
    step();
    bus.net_in_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      bus.net_in_pack = {5'($urandom_range(0, 31)), 5'($urandom_range(2, 31)), 10'($urandom_range(0, 1023))};
      step();
    end
    bus.net_in_valid = 1'b0;
    #1;
    check("drop_cnt_sat", 20'(bus.drop_cnt), 20'd255);
    step();

    // Loopback collides with a network packet for this leaf
    bus.pe_rx_ready  = 1'b0;
    bus.net_in_valid = 1'b1;
    bus.net_in_pack  = {5'd9, 5'd1, 2'd2, 8'h55};
    pe_send(5'd1, 2'd3, 8'h77);
    step();
    bus.net_in_valid = 1'b0;
    step();
    bus.pe_tx_valid = 1'b0;
    #1;
    check("loop_first", 20'(bus.pe_rx_data), 20'h55);
    bus.pe_rx_ready = 1'b1;
    step();
    #1;
    check("loop_second", 20'(bus.pe_rx_data), 20'h77);
    check("loop_src", 20'(bus.pe_rx_src), 20'd1);
    step();
    step();

    // Random traffic across both paths
    for (int i = 0; i < 600; i++) begin
      bus.pe_tx_valid   = 1'($urandom_range(0, 1));
      bus.pe_tx_dest    = ($urandom_range(0, 2) == 0) ? 5'd1 : 5'($urandom_range(2, 31));
      bus.pe_tx_type    = 2'($urandom_range(0, 3));
      bus.pe_tx_data    = 8'($urandom_range(0, 255));
      bus.net_in_valid  = 1'($urandom_range(0, 1));
      bus.net_in_pack   = {5'($urandom_range(0, 31)),
                           ($urandom_range(0, 3) != 0) ? 5'd1 : 5'($urandom_range(2, 31)),
                           10'($urandom_range(0, 1023))};
      bus.net_out_ready = ($urandom_range(0, 3) != 0);
      bus.pe_rx_ready   = ($urandom_range(0, 3) != 0);
      step();
    end

    // Reset with both FIFOs partly occupied
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      pe_send(5'd6, 2'd1, 8'(8'h40 + i));
      bus.net_in_valid = 1'b1;
      bus.net_in_pack  = {5'd4, 5'd1, 2'd0, 8'(8'h90 + i)};
      step();
    end
    bus.net_in_valid = 1'b1;
    bus.net_in_pack  = {5'd4, 5'd9, 2'd0, 8'hEE};
    step();
    reset = 1'b1;
    #1;
    check("rst_net_out_valid", 20'(bus.net_out_valid), 20'd0);
    check("rst_pe_rx_valid", 20'(bus.pe_rx_valid), 20'd0);
    check("rst_pe_tx_ready", 20'(bus.pe_tx_ready), 20'd0);
    check("rst_drop_cnt", 20'(bus.drop_cnt), 20'd0);
    step();
    idle_inputs();
    reset = 1'b0;
    bus.net_out_ready = 1'b1;
    bus.pe_rx_ready   = 1'b1;
    for (int i = 0; i < 4; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
